// File: rtl/fifo_mc_pkg.sv
// Shared constants, types and helpers for the single-clock multi-channel FIFO.
package fifo_mc_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDR_SIZE = 4;
  localparam int DEF_NUM_CH    = 4;

  function automatic int cnt_width(input int addr_size);
    return addr_size + 1;
  endfunction

  // Per-channel bookkeeping at the default depth.
  typedef struct packed {
    logic [DEF_ADDR_SIZE-1:0] wptr;
    logic [DEF_ADDR_SIZE-1:0] rptr;
    logic [DEF_ADDR_SIZE:0]   count;
  } ch_state_t;

  function automatic int flat_addr(input int ch, input int ptr, input int addr_size);
    return (ch << addr_size) + ptr;
  endfunction

endpackage

// File: rtl/fifo_mc_ch_ctrl.sv
// Pointer, occupancy and status-flag controller for one FIFO channel.
module fifo_mc_ch_ctrl
  import fifo_mc_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_hit,
  input  logic                 rd_hit,
  output logic                 wr_acc,
  output logic                 rd_acc,
  output logic [ADDR_SIZE-1:0] wptr,
  output logic [ADDR_SIZE-1:0] rptr,
  output logic [ADDR_SIZE:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf,
  output logic                 udf
);

  localparam int CW    = cnt_width(ADDR_SIZE);
  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [ADDR_SIZE-1:0] wptr_r, rptr_r, wptr_s, rptr_s;
  logic [CW-1:0]        count_r, count_s;
  logic                 full_r, empty_r, ovf_r, udf_r;
  logic                 wr_acc_s, rd_acc_s;

  // Acceptance uses start-of-cycle flags, so a full channel still drains and an empty one still fills.
  always_comb begin
    wr_acc_s = wr_hit && !full_r;
    rd_acc_s = rd_hit && !empty_r;
    wptr_s   = wr_acc_s ? wptr_r + ADDR_SIZE'(1) : wptr_r;
    rptr_s   = rd_acc_s ? rptr_r + ADDR_SIZE'(1) : rptr_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // Channel state register; flags are derived from next count so they stay consistent with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      wptr_r  <= wptr_s;
      rptr_r  <= rptr_s;
      count_r <= count_s;
      full_r  <= (count_s == CW'(DEPTH));
      empty_r <= (count_s == CW'(0));
      ovf_r   <= ovf_r | (wr_hit & full_r);
      udf_r   <= udf_r | (rd_hit & empty_r);
    end
  end

  assign wr_acc = wr_acc_s;
  assign rd_acc = rd_acc_s;
  assign wptr   = wptr_r;
  assign rptr   = rptr_r;
  assign count  = count_r;
  assign full   = full_r;
  assign empty  = empty_r;
  assign ovf    = ovf_r;
  assign udf    = udf_r;

endmodule

// File: rtl/fifo_mc_memory.sv
// Single-clock multi-channel FIFO: shared RAM split into NUM_CH circular queues.
// Optional FIFO_MC_PARITY_EN adds a stored even-parity bit and the rd_par_err pulse.
module fifo_mc_memory
  import fifo_mc_pkg::*;
#(
  parameter int  DATA_SIZE = DEF_DATA_SIZE,
  parameter int  ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int  NUM_CH    = DEF_NUM_CH,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [CH_W-1:0]                 wr_ch,
  input  logic [DATA_SIZE-1:0]            wr_data,
  input  logic                            rd_en,
  input  logic [CH_W-1:0]                 rd_ch,
  output logic [DATA_SIZE-1:0]            rd_data,
  output logic                            rd_valid,
  output logic [NUM_CH-1:0]               full,
  output logic [NUM_CH-1:0]               empty,
  output logic [NUM_CH-1:0]               ovf,
  output logic [NUM_CH-1:0]               udf,
  output logic [NUM_CH*(ADDR_SIZE+1)-1:0] count
`ifdef FIFO_MC_PARITY_EN
  ,
  output logic                            rd_par_err
`endif
);

  localparam int CW    = cnt_width(ADDR_SIZE);
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int AW    = CH_W + ADDR_SIZE;
`ifdef FIFO_MC_PARITY_EN
  localparam int WW    = DATA_SIZE + 1;
`else
  localparam int WW    = DATA_SIZE;
`endif

  logic [WW-1:0]        mem_r [NUM_CH*DEPTH];
  logic [NUM_CH-1:0]    wr_hit_s, rd_hit_s, wr_acc_s, rd_acc_s;
  logic [ADDR_SIZE-1:0] wptr_s [NUM_CH];
  logic [ADDR_SIZE-1:0] rptr_s [NUM_CH];
  logic [ADDR_SIZE-1:0] wr_ptr_s, rd_ptr_s;
  logic [AW-1:0]        waddr_s, raddr_s;
  logic [WW-1:0]        wr_word_s, rd_word_s;
  logic                 wr_any_s, rd_any_s;
  logic [DATA_SIZE-1:0] rd_data_r;
  logic                 rd_valid_r;

  // Channel-select decode; an index beyond NUM_CH matches no channel and is silently dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i] = wr_en && (wr_ch == CH_W'(i));
      rd_hit_s[i] = rd_en && (rd_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fifo_mc_ch_ctrl #(.ADDR_SIZE(ADDR_SIZE)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_hit (wr_hit_s[g]),
      .rd_hit (rd_hit_s[g]),
      .wr_acc (wr_acc_s[g]),
      .rd_acc (rd_acc_s[g]),
      .wptr   (wptr_s[g]),
      .rptr   (rptr_s[g]),
      .count  (count[g*CW +: CW]),
      .full   (full[g]),
      .empty  (empty[g]),
      .ovf    (ovf[g]),
      .udf    (udf[g])
    );
  end

  // At most one channel accepts each direction, so OR-muxing its pointer is exact.
  always_comb begin
    wr_ptr_s = '0;
    rd_ptr_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr_s = wr_ptr_s | (wr_acc_s[i] ? wptr_s[i] : '0);
      rd_ptr_s = rd_ptr_s | (rd_acc_s[i] ? rptr_s[i] : '0);
    end
    wr_any_s = |wr_acc_s;
    rd_any_s = |rd_acc_s;
    waddr_s  = AW'(flat_addr(int'(wr_ch), int'(wr_ptr_s), ADDR_SIZE));
    raddr_s  = AW'(flat_addr(int'(rd_ch), int'(rd_ptr_s), ADDR_SIZE));
`ifdef FIFO_MC_PARITY_EN
    wr_word_s = {^wr_data, wr_data};
`else
    wr_word_s = wr_data;
`endif
    rd_word_s = mem_r[raddr_s];
  end

  // Shared storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_any_s) begin
      mem_r[waddr_s] <= wr_word_s;
    end
  end

  // Read-data register: one-cycle latency, holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_any_s;
      if (rd_any_s) begin
        rd_data_r <= rd_word_s[DATA_SIZE-1:0];
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

`ifdef FIFO_MC_PARITY_EN
  logic rd_par_err_r;

  // Parity check pulse, aligned with rd_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_par_err_r <= 1'b0;
    end else begin
      rd_par_err_r <= rd_any_s && ((^rd_word_s[DATA_SIZE-1:0]) != rd_word_s[DATA_SIZE]);
    end
  end

  assign rd_par_err = rd_par_err_r;
`endif

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_fifo_mc_memory.sv
// Scoreboard bench for fifo_mc_memory at default parameters (4 channels x 16 words x 8 bits).
module tb_fifo_mc_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [1:0]  wr_ch, rd_ch;
  logic [7:0]  wr_data, rd_data;
  logic        rd_valid;
  logic [3:0]  full, empty, ovf, udf;
  logic [19:0] count;
`ifdef FIFO_MC_PARITY_EN
  logic        rd_par_err;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_mc_memory dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_ch    (rd_ch),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .udf      (udf),
    .count    (count)
`ifdef FIFO_MC_PARITY_EN
    ,
    .rd_par_err (rd_par_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return {27'd0, count[ch*5 +: 5]};
  endfunction

  // One clock of stimulus; an expected read word is queued when the read should be accepted.
  task automatic step(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                      input logic re, input logic [1:0] rc,
                      input logic push, input logic [7:0] ed);
    wr_en = we; wr_ch = wc; wr_data = wd;
    rd_en = re; rd_ch = rc;
    if (push) exp_q.push_back(ed);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_ch = 2'd0; wr_data = 8'h00;
    rd_en = 1'b0; rd_ch = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", {28'd0, empty}, 32'hF);
    chk("rst_full", {28'd0, full}, 32'h0);
    chk("rst_flags", {24'd0, ovf, udf}, 32'h0);
    chk("rst_count", {12'd0, count}, 32'h0);
    chk("rst_rd", {23'd0, rd_valid, rd_data}, 32'h0);
    rst_n = 1'b1;
    idle();

    // ch1: three writes then three reads
    step(1'b1, 2'd1, 8'h11, 1'b0, 2'd0, 1'b0, 8'h00);
    step(1'b1, 2'd1, 8'h22, 1'b0, 2'd0, 1'b0, 8'h00);
    step(1'b1, 2'd1, 8'h33, 1'b0, 2'd0, 1'b0, 8'h00);
    chk("ch1_count3", cnt(1), 32'd3);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h11);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h22);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 8'h33);
    idle();
    chk("ch1_count0", cnt(1), 32'd0);
    chk("ch1_empty", {31'd0, empty[1]}, 32'd1);

    // ch2: fill, overflow attempt, drain, then wrap
    for (int i = 0; i < 16; i++) step(1'b1, 2'd2, 8'(i), 1'b0, 2'd0, 1'b0, 8'h00);
    chk("ch2_full", {31'd0, full[2]}, 32'd1);
    chk("ch2_no_ovf_yet", {31'd0, ovf[2]}, 32'd0);
    step(1'b1, 2'd2, 8'hAA, 1'b0, 2'd0, 1'b0, 8'h00);
    chk("ch2_ovf", {28'd0, ovf}, 32'h4);
    chk("ch2_count16", cnt(2), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'(i));
    idle();
    chk("ch2_drained", {27'd0, empty[2], cnt(2)[3:0]}, 32'h10);
    step(1'b1, 2'd2, 8'h99, 1'b0, 2'd0, 1'b0, 8'h00);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 8'h99);
    idle();

    // ch0: underflow, then simultaneous write/read on empty channel
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00);
    chk("ch0_udf", {28'd0, udf}, 32'h1);
    chk("ch0_udf_novalid", {31'd0, rd_valid}, 32'd0);
    chk("ch0_udf_hold", {24'd0, rd_data}, 32'h99);
    step(1'b1, 2'd0, 8'h5A, 1'b1, 2'd0, 1'b0, 8'h00);
    chk("ch0_simul_count", cnt(0), 32'd1);
    chk("ch0_simul_novalid", {31'd0, rd_valid}, 32'd0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'h5A);
    idle();

    // ch3: simultaneous write/read on full channel
    for (int i = 0; i < 16; i++) step(1'b1, 2'd3, 8'h30 + 8'(i), 1'b0, 2'd0, 1'b0, 8'h00);
    step(1'b1, 2'd3, 8'h77, 1'b1, 2'd3, 1'b1, 8'h30);
    chk("ch3_ovf", {28'd0, ovf}, 32'hC);
    chk("ch3_count15", cnt(3), 32'd15);
    chk("ch3_not_full", {31'd0, full[3]}, 32'd0);
    for (int i = 1; i < 16; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 8'h30 + 8'(i));
    idle();
    chk("ch3_empty", {31'd0, empty[3]}, 32'd1);

    // Interleaved traffic on ch0/ch1
    step(1'b1, 2'd1, 8'hB0, 1'b0, 2'd0, 1'b0, 8'h00);
    step(1'b1, 2'd1, 8'hB1, 1'b0, 2'd0, 1'b0, 8'h00);
    step(1'b1, 2'd0, 8'hA0, 1'b1, 2'd1, 1'b1, 8'hB0);
    step(1'b1, 2'd1, 8'hB2, 1'b1, 2'd1, 1'b1, 8'hB1);
    step(1'b1, 2'd0, 8'hA1, 1'b1, 2'd1, 1'b1, 8'hB2);
    chk("mix_count0", cnt(0), 32'd2);
    chk("mix_count1", cnt(1), 32'd0);
    step(1'b1, 2'd0, 8'hA2, 1'b1, 2'd0, 1'b1, 8'hA0);
    chk("mix_count0_same", cnt(0), 32'd2);
    idle();

    // Reset in the middle of a burst
    step(1'b1, 2'd0, 8'hA3, 1'b0, 2'd0, 1'b0, 8'h00);
    chk("pre_rst_count0", cnt(0), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", {12'd0, count}, 32'h0);
    chk("mid_rst_empty_full", {24'd0, empty, full}, 32'hF0);
    chk("mid_rst_flags", {24'd0, ovf, udf}, 32'h0);
    chk("mid_rst_rd", {23'd0, rd_valid, rd_data}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00);
    chk("post_rst_udf", {28'd0, udf}, 32'h1);

`ifdef FIFO_MC_PARITY_EN
    step(1'b1, 2'd0, 8'h0F, 1'b0, 2'd0, 1'b0, 8'h00);
    dut.mem_r[0] = dut.mem_r[0] ^ 9'h001;
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'h0E);
    @(negedge clk);
    chk("par_err_pulse", {30'd0, rd_valid, rd_par_err}, 32'h3);
    @(posedge clk);
    #1;
    chk("par_err_clear", {31'd0, rd_par_err}, 32'd0);
`endif

    idle();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
